imem_read_responder: RTL and testbench



---
 rtl/imem_read_responder.sv | 116 +++++++++++
 tb/tb_imem_read_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_read_responder.sv
// imem_read_responder: instruction memory answering start_read with a ready pulse after WAIT_CYCLES wait states.
// Define IMEM_HIT_BUFFER_EN to add a one-entry buffer that serves repeat reads at zero-wait latency.
module imem_read_responder #(
    parameter int    ADDR_WORDS_LOG2 = 10,
    parameter int    WAIT_CYCLES     = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_read,
    input  logic [31:0] address,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        misaligned,
    output logic        range_err
);
    localparam int AW    = ADDR_WORDS_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [AW-1:0] r_idx;
    logic          r_oor;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_idx, w_prog_idx;
    logic          w_oor, w_prog_ok, w_accept, w_hit, w_wr_same, w_unused;
    logic [31:0]   w_rdata;

    assign w_idx      = address[AW+1:2];
    assign w_oor      = |address[31:AW+2];
    assign w_prog_idx = prog_addr[AW+1:2];
    assign w_prog_ok  = prog_we && ~|prog_addr[31:AW+2];
    // The ready cycle is still IDLE in the FSM, so it is masked here to drop requests landing on it
    assign w_accept   = r_state == S_IDLE && start_read && !ready;
    assign w_wr_same  = w_prog_ok && w_prog_idx == r_idx;
    assign busy       = r_state != S_IDLE || ready;
    assign w_unused   = ^prog_addr[1:0];

`ifdef IMEM_HIT_BUFFER_EN
    logic          r_hb_valid, r_hit;
    logic [AW-1:0] r_hb_idx;
    logic [31:0]   r_hb_data;

    // A write landing on the acceptance edge would make the buffered copy stale, so it forces a miss
    assign w_hit   = r_hb_valid && r_hb_idx == w_idx && !w_oor && !(w_prog_ok && w_prog_idx == w_idx);
    assign w_rdata = r_oor ? '0 : w_wr_same ? prog_data : r_hit ? r_hb_data : r_mem[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_valid <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            if (w_accept) r_hit <= w_hit;
            if (w_prog_ok && w_prog_idx == r_hb_idx) r_hb_valid <= 1'b0;
            if (r_state == S_RESP && !r_oor) begin
                r_hb_valid <= 1'b1;
                r_hb_idx   <= r_idx;
                r_hb_data  <= w_rdata;
            end
        end
    end
`else
    assign w_hit   = 1'b0;
    assign w_rdata = r_oor ? '0 : w_wr_same ? prog_data : r_mem[r_idx];
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_cnt_next   = w_hit ? 4'd0 : 4'(WAIT_CYCLES);
                w_state_next = (WAIT_CYCLES == 0 || w_hit) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                w_cnt_next   = r_cnt - 4'd1;
                w_state_next = r_cnt <= 4'd1 ? S_RESP : S_WAIT;
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_oor      <= 1'b0;
            ready      <= 1'b0;
            read_data  <= '0;
            misaligned <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            ready   <= r_state == S_RESP;
            if (r_state == S_RESP) read_data <= w_rdata;
            if (w_accept) begin
                r_idx      <= w_idx;
                r_oor      <= w_oor;
                misaligned <= misaligned | (|address[1:0]);
                range_err  <= range_err | w_oor;
            end
        end
    end

    always_ff @(posedge clk)
        if (w_prog_ok) r_mem[w_prog_idx] <= prog_data;
endmodule

// File: tb/tb_imem_read_responder.sv
// tb_imem_read_responder: randomized scoreboard bench; a spec-level model predicts data, latency and flags.
module tb_imem_read_responder;
    localparam int W = 2;
`ifdef IMEM_HIT_BUFFER_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, start_read = 1'b0, prog_we = 1'b0;
    logic [31:0] address = '0, prog_addr = '0, prog_data = '0;
    logic [31:0] read_data;
    logic        ready, busy, misaligned, range_err;

    imem_read_responder #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .start_read(start_read), .address(address),
        .read_data(read_data), .ready(ready), .busy(busy),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .misaligned(misaligned), .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0, checks = 0;
    logic [31:0] mdl [1024];
    bit          m_mis = 1'b0, m_rng = 1'b0, hb_v = 1'b0;
    int          hb_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ready) begin
            chk("busy_in_ready", {31'd0, busy}, 32'd1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("read_data", read_data, e.data);
                chk("ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        if (a[31:12] == 0) begin
            mdl[a[11:2]] = d;
            if (q.size() == 0 && hb_v && hb_idx == int'(a[11:2])) hb_v = 1'b0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input bit use_ovr, input logic [31:0] ovr);
        exp_t e;
        bit   oor = a[31:12] != 0;
        int   idx = int'(a[11:2]);
        bit   hit = HB && hb_v && hb_idx == idx && !oor;
        e.data = oor ? 32'h0 : use_ovr ? ovr : mdl[idx];
        e.cyc  = cyc + 2 + (hit ? 0 : W);
        q.push_back(e);
        m_mis |= a[1:0] != 0;
        m_rng |= oor;
        if (!oor) begin
            hb_v = 1'b1;
            hb_idx = idx;
        end
        start_read = 1'b1; address = a;
        @(negedge clk);
        start_read = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout: got no ready expected %0d responses", q.size());
            q.delete();
        end
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        chk("range_err", {31'd0, range_err}, {31'd0, m_rng});
    endtask

    task automatic do_read(input logic [31:0] a);
        issue(a, 1'b0, 32'h0);
        wait_done();
    endtask

    initial begin
        int seen;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) do_prog(32'(i * 4), $urandom);
        do_prog(32'h0000000C, 32'h8C220004);
        do_prog(32'h00000020, 32'h00A0B0C0);

        do_read(32'h0000000C);

        // Write one cycle after acceptance plus an ignored start_read while busy
        issue(32'h00000014, 1'b1, 32'hDEADBEEF);
        prog_we = 1'b1; prog_addr = 32'h14; prog_data = 32'hDEADBEEF;
        start_read = 1'b1; address = 32'h00001001;
        @(negedge clk);
        prog_we = 1'b0; start_read = 1'b0;
        mdl[5] = 32'hDEADBEEF;
        wait_done();
        repeat (6) @(negedge clk);

        // Write landing exactly on the response edge is returned
        issue(32'h00000018, 1'b1, 32'hCAFEF00D);
        repeat (W) @(negedge clk);
        prog_we = 1'b1; prog_addr = 32'h18; prog_data = 32'hCAFEF00D;
        @(negedge clk);
        prog_we = 1'b0;
        mdl[6] = 32'hCAFEF00D;
        wait_done();

        do_read(32'h00000006);
        do_read(32'h00000010);
        do_read(32'h00001000);
        do_prog(32'h00001000, 32'h12345678);
        do_read(32'h00000000);

        // Reset while waiting discards the request
        start_read = 1'b1; address = 32'h00000008;
        @(negedge clk);
        start_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_mis = 1'b0; m_rng = 1'b0; hb_v = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        chk("no_ready_after_rst", seen, 0);
        chk("misaligned_cleared", {31'd0, misaligned}, 32'd0);
        do_read(32'h0000000C);

        do_read(32'h00000020);
        do_read(32'h00000020);
        do_prog(32'h00000020, 32'h13579BDF);
        do_read(32'h00000020);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 19) < 5) begin
                a = $urandom_range(0, 9) == 0 ? 32'h00001000 | 32'($urandom_range(0, 15) * 4)
                                              : 32'($urandom_range(0, 15) * 4);
                do_prog(a, $urandom);
            end else begin
                a = 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 14) == 0) a = 32'h00001000 << $urandom_range(0, 19);
                do_read(a);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
